// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 2-digit display scheduler.
package display_pkg;

  localparam int              BIN_W      = 7;
  localparam logic [BIN_W-1:0] MAX_VALUE = 7'd99;
  localparam logic [7:0]      BLANK_CODE = 8'hFF;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/display_if.sv
// Requester handshake plus display-side outputs of the scheduler.
interface display_if #(
  parameter int NUM_REQ = 4
);
  import display_pkg::*;

  logic [NUM_REQ-1:0]         req_valid_i;
  logic [NUM_REQ*BIN_W-1:0]   req_data_i;
  logic [NUM_REQ-1:0]         req_ready_o;
  logic [7:0]                 bcd_o;
  logic                       bcd_valid_o;
  logic                       update_o;
  logic [$clog2(NUM_REQ)-1:0] owner_o;
  logic                       busy_o;

  modport master (
    output req_valid_i, req_data_i,
    input  req_ready_o, bcd_o, bcd_valid_o, update_o, owner_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_data_i,
    output req_ready_o, bcd_o, bcd_valid_o, update_o, owner_o, busy_o
  );

endinterface

// File: rtl/display_scheduler_bin2bcd_seq.sv
// Sequential double-dabble: one bit per cycle, 7-cycle latency after start_i,
// values above 99 come out as the blank code.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             done_o,
  output logic [7:0]       bcd_o
);

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [7:0]       bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             active_q, active_d;
  logic [3:0]       tens_adj, units_adj;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    tens_adj  = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    units_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    if (start_i) begin
      bin_d    = bin_i;
      bcd_d    = '0;
      ovf_d    = (bin_i > MAX_VALUE);
      cnt_d    = 3'(BIN_W);
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q != '0) begin
        bcd_d = {tens_adj[2:0], units_adj, bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - 3'd1;
      end else begin
        active_d = 1'b0;
      end
    end
  end

  // NOTE: only control state is reset; the shift datapath is fully reloaded on every start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    bin_q <= bin_d;
    bcd_q <= bcd_d;
    ovf_q <= ovf_d;
  end

  assign done_o = active_q && (cnt_q == '0);
  assign bcd_o  = ovf_q ? BLANK_CODE : bcd_q;

endmodule

// File: rtl/display_scheduler.sv
// Round-robin scheduler sharing one 2-digit BCD display between NUM_REQ requesters.
// Optional DISP_PREEMPT_EN: requester 0 may cut short another requester's hold.
module display_scheduler
  import display_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 27000000
) (
  input  logic      clk_i,
  input  logic      rst_i,
  display_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d, owner_q, owner_d;
  logic [IDX_W-1:0] winner, cand;
  logic [7:0]       bcd_q, bcd_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic             update_q, update_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_valid, conv_start, conv_done;
  logic [7:0]       conv_bcd;
  logic [BIN_W-1:0] grant_data;
  logic [NUM_REQ-1:0] ready;
`ifdef DISP_PREEMPT_EN
  logic             preempt_q, preempt_d;
`endif

  // Descending scan so the index closest after last_q is the one that sticks.
  always_comb begin
    winner    = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (bus.req_valid_i[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
`ifdef DISP_PREEMPT_EN
    if (preempt_q && bus.req_valid_i[0]) winner = '0;
`endif
  end

  assign conv_start = (state_q == ARB) && any_valid;
  assign grant_data = bus.req_data_i[int'(winner)*BIN_W +: BIN_W];

  always_comb begin
    ready = '0;
    if (conv_start) ready[winner] = 1'b1;
  end

  bin2bcd_seq u_conv (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(conv_start),
    .bin_i  (grant_data),
    .done_o (conv_done),
    .bcd_o  (conv_bcd)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    bcd_d       = bcd_q;
    bcd_valid_d = bcd_valid_q;
    update_d    = 1'b0;
    cnt_d       = cnt_q;
`ifdef DISP_PREEMPT_EN
    preempt_d   = preempt_q;
`endif
    unique case (state_q)
      ARB: begin
        if (any_valid) begin
          owner_d = winner;
          last_d  = winner;
          state_d = CONVERT;
`ifdef DISP_PREEMPT_EN
          preempt_d = 1'b0;
`endif
        end
      end
      CONVERT: begin
        if (conv_done) begin
          bcd_d       = conv_bcd;
          update_d    = 1'b1;
          bcd_valid_d = 1'b1;
          cnt_d       = CNT_W'(HOLD_CYCLES - 1);
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = ARB;
        else             cnt_d   = cnt_q - 1'b1;
`ifdef DISP_PREEMPT_EN
        if (bus.req_valid_i[0] && (owner_q != '0)) begin
          state_d   = ARB;
          preempt_d = 1'b1;
        end
`endif
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB;
      last_q      <= IDX_W'(NUM_REQ - 1);
      owner_q     <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      update_q    <= 1'b0;
      cnt_q       <= '0;
`ifdef DISP_PREEMPT_EN
      preempt_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      update_q    <= update_d;
      cnt_q       <= cnt_d;
`ifdef DISP_PREEMPT_EN
      preempt_q   <= preempt_d;
`endif
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.bcd_o       = bcd_q;
  assign bus.bcd_valid_o = bcd_valid_q;
  assign bus.update_o    = update_q;
  assign bus.owner_o     = owner_q;
  assign bus.busy_o      = (state_q != ARB);

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
Shares the 2-digit multiplexed 7-segment display between NUM_REQ requesters, each offering a binary value 0..99.
- Round-robin arbitration with valid/ready handshake.
- Sequential binary-to-BCD conversion (double-dabble, one bit per cycle).
- Holds each winner's value for HOLD_CYCLES before re-arbitrating.
- bcd_o drives the bcd input of the downstream 7-segment driver.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
HOLD_CYCLES, 27000000, cycles a granted value stays displayed (1 s at 27 MHz)

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset; one clock, synchronous, active-high
req_valid_i  input  NUM_REQ  per-requester valid; held high until accepted
req_data_i  input  NUM_REQ*7  requester k's value at bits [7k+6:7k], binary
req_ready_o  output  NUM_REQ  one-hot accept; combinational from state and grant
bcd_o  output  8  [7:4] tens, [3:0] units; 8'hFF = blank
bcd_valid_o  output  1  high once any value has been shown; cleared only by reset
update_o  output  1  one-cycle pulse when bcd_o changes
owner_o  output  $clog2(NUM_REQ)  index of requester currently displayed
busy_o  output  1  high in CONVERT or HOLD

Behaviour:
- Reset values: bcd_o=8'h00, bcd_valid_o=0, update_o=0, owner_o=0, req_ready_o=0, busy_o=0, state ARB.
- Reset values: round-robin pointer last=NUM_REQ-1, so requester 0 has first priority; hold counter=0.
- Reset mid-operation aborts any conversion or hold; the captured value is discarded.
- FSM states: ARB, CONVERT, HOLD.
- ARB:
  - Winner is the first asserted req_valid_i index searching last+1, last+2, ... modulo NUM_REQ.
  - req_ready_o[winner]=1 in the same cycle, so the transfer occurs at that edge (T).
  - At T: capture data, owner_o<=winner, last<=winner, state->CONVERT.
  - With no valid asserted: stay in ARB, all outputs hold, ready=0.
- req_ready_o is 0 outside ARB and is never asserted to an index whose valid is low.
- CONVERT:
  - 7 iterations, T+1..T+7: add 3 to any BCD nibble >=5, then shift in the next data bit, MSB first.
  - At the T+8 edge: bcd_o updated, update_o pulses for 1 cycle, bcd_valid_o<=1, counter<=HOLD_CYCLES-1, state->HOLD.
  - Captured value >99: conversion still takes 7 cycles (fixed latency) and bcd_o<=8'hFF (blank).
- bcd_o keeps its previous value through ARB and CONVERT, so the display does not flicker.
- HOLD:
  - Counter decrements each cycle.
  - At 0, state->ARB next cycle; bcd_o stable for exactly HOLD_CYCLES cycles in HOLD.
- Same value re-requested: still produces an update_o pulse.
- Requester dropping valid without being accepted is legal and has no effect.

Optional Feature:
DISP_PREEMPT_EN:
- Defined: in HOLD, if req_valid_i[0]=1 and owner_o!=0, the hold ends the next cycle (state->ARB).
  - In that ARB cycle requester 0 is granted regardless of the pointer; last<=0.
  - No preemption during CONVERT.
- Undefined: requester 0 has no special priority; HOLD always runs its full length.

Decomposition:
- Package display_pkg holds:
  - state encoding enum (ARB, CONVERT, HOLD);
  - BLANK_CODE=8'hFF;
  - MAX_VALUE=7'd99;
  - BIN_W=7.
- Sub-module bin2bcd_seq: sequential double-dabble with start_i/done_o, 7-cycle latency, overflow to BLANK_CODE.
- The scheduler FSM, arbiter and hold counter stay in display_scheduler.

Test Plan:
- Reset: rst_i=1 for 2 cycles -> bcd_o=8'h00, bcd_valid_o=0, ready=0; no activity while all valid=0. Bench uses HOLD_CYCLES=10, NUM_REQ=4.
- Single request: valid[2]=1, data=7'd47 -> ready[2] for 1 cycle; 8 cycles later bcd_o=8'h47, update_o pulse, owner_o=2; stable for 10 cycles.
- Round-robin: all valid high, data 5/16/99/120 -> shown order 8'h05, 8'h16, 8'h99, 8'hFF, then 8'h05; owner_o 0,1,2,3,0.
- Reset mid-CONVERT: rst_i asserted 3 cycles after grant -> no update_o, bcd_o=8'h00, next grant goes to requester 0.
- Hold timing: request 33 and, after its grant, request 64 -> 8'h33 stays exactly 10 cycles; 8'h64 appears 10+1+8 cycles after the 8'h33 update.
- DISP_PREEMPT_EN: owner_o=1 in HOLD at count 7, valid[0] set with data 12 -> hold aborted, ready[0] next cycle, 8'h12 shown 8 cycles later; same stimulus without the macro -> full hold first.
